// File: rtl/saradc_11b_dig_loopback_chk.sv
// SAR ADC digital-interface loopback self-test: issues LFSR vectors onto the looped-back
// control fields in scan mode and checks the folded response returned on sar/comp/track.
module saradc_11b_dig_loopback_chk #(
  parameter int N_CHANNELS = 16,
  parameter int SAR_MSB    = 12,
  parameter int CAL_MSB    = 5,
  parameter int TRACK_MSB  = 4,
  parameter int RSP_LAT    = 2,
  parameter int N_VECTORS  = 256,
  parameter int ERRCNT_W   = 8,
  localparam int VEC_W  = N_CHANNELS + CAL_MSB + SAR_MSB + TRACK_MSB + 20,
  localparam int FOLD_W = SAR_MSB + TRACK_MSB + 3,
  localparam int IDX_W  = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [31:0]         seed_i,
  output logic                scan_mode_o,
  output logic [VEC_W-1:0]    lb_vec_o,
  input  logic [FOLD_W-1:0]   fold_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [ERRCNT_W-1:0] err_cnt_o,
  output logic [IDX_W-1:0]    first_err_idx_o
);

  localparam int DR_W = (RSP_LAT > 1) ? $clog2(RSP_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_VECTORS - 1);
  localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(RSP_LAT - 1);
  localparam logic [31:0]      LFSR_TAPS  = 32'h8020_0003;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                               state_q, state_d;
  logic [31:0]                          lfsr_q, lfsr_d;
  logic [VEC_W-1:0]                     vec_q, vec_d;
  logic [IDX_W-1:0]                     cnt_q, cnt_d;
  logic [DR_W-1:0]                      drain_q, drain_d;
  logic [RSP_LAT-1:0]                   pv_q, pv_d;
  logic [RSP_LAT-1:0][FOLD_W-1:0]       pf_q, pf_d;
  logic [RSP_LAT-1:0][IDX_W-1:0]        pi_q, pi_d;
  logic [ERRCNT_W-1:0]                  err_q, err_d;
  logic [IDX_W-1:0]                     first_q, first_d;
  logic                                 seen_q, seen_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;
  logic                                 pass_q, pass_d;
  logic [VEC_W-1:0]                     vec_next_s;
  logic                                 mismatch_s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [VEC_W-1:0] make_vec(input logic [31:0] l);
    make_vec = VEC_W'({l ^ {l[15:0], l[31:16]}, l});
  endfunction

  // Bit b lands in fold bit b mod FOLD_W: full chunks XOR, a partial top chunk zero-extends.
  function automatic logic [FOLD_W-1:0] fold_vec(input logic [VEC_W-1:0] v);
    logic [FOLD_W-1:0] f;
    f = '0;
    for (int b = 0; b < VEC_W; b++) begin
      f[b % FOLD_W] ^= v[b];
    end
    return f;
  endfunction

  // Next-state, datapath and result computation.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    err_d      = err_q;
    first_d    = first_q;
    seen_d     = seen_q;
    vec_next_s = make_vec(lfsr_q);
    mismatch_s = pv_q[RSP_LAT-1] && (fold_i != pf_q[RSP_LAT-1]);
    pv_d[0]    = 1'b0;
    pf_d[0]    = fold_vec(vec_next_s);
    pi_d[0]    = cnt_q;
    for (int i = 1; i < RSP_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pf_d[i] = pf_q[i-1];
      pi_d[i] = pi_q[i-1];
    end

    if (mismatch_s) begin
      if (err_q != '1) begin
        err_d = err_q + ERRCNT_W'(1);
      end else begin
        err_d = err_q;
      end
      if (!seen_q) begin
        first_d = pi_q[RSP_LAT-1];
        seen_d  = 1'b1;
      end else begin
        first_d = first_q;
      end
    end else begin
      err_d = err_q;
    end

    if (abort_i) begin
      state_d = S_IDLE;
      lfsr_d  = '0;
      vec_d   = '0;
      cnt_d   = '0;
      drain_d = '0;
      pv_d    = '0;
      err_d   = '0;
      first_d = '0;
      seen_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d = S_RUN;
            lfsr_d  = (seed_i == 32'h0000_0000) ? 32'h0000_0001 : seed_i;
            cnt_d   = '0;
            err_d   = '0;
            first_d = '0;
            seen_d  = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_RUN: begin
          vec_d   = vec_next_s;
          lfsr_d  = lfsr_step(lfsr_q);
          pv_d[0] = 1'b1;
          cnt_d   = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = S_DONE;
            vec_d   = '0;
          end else begin
            drain_d = drain_q + DR_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          vec_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      pv_q    <= '0;
      pf_q    <= '0;
      pi_q    <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      pv_q    <= pv_d;
      pf_q    <= pf_d;
      pi_q    <= pi_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign scan_mode_o     = busy_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign lb_vec_o        = vec_q;
  assign err_cnt_o       = err_q;
  assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_saradc_11b_dig_loopback_chk.sv
// Directed bench for the SAR ADC loopback checker: table of full runs plus abort, DRAIN-start
// and mid-DRAIN reset sequences, against an independent vector/fold/response model.
module tb_saradc_11b_dig_loopback_chk;

  localparam int VEC_W  = 57;
  localparam int FOLD_W = 19;
  localparam int NV     = 256;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              abort_i;
  logic [31:0]       seed_i;
  logic              scan_mode_o;
  logic [VEC_W-1:0]  lb_vec_o;
  logic [FOLD_W-1:0] fold_i;
  logic              busy_o;
  logic              done_o;
  logic              pass_o;
  logic [7:0]        err_cnt_o;
  logic [7:0]        first_err_idx_o;

  int n_chk  = 0;
  int n_fail = 0;

  // response model controls: delay 2 = ideal, 3 = one cycle late; mode 1 flips bit 3 of vector 17, 2 = stuck 0
  int mdl_delay = 2;
  int mdl_mode  = 0;
  int cyc = 0;
  int ht0 = 0;
  int ht1 = 0;
  logic [FOLD_W-1:0] hf0 = '0;
  logic [FOLD_W-1:0] hf1 = '0;
  logic [FOLD_W-1:0] sel_f;
  int sel_t;

  typedef struct {
    logic [31:0] seed;
    int          delay;
    int          mode;
    int          exp_err;
    int          exp_first;
    logic        exp_pass;
  } rec_t;

  rec_t tbl[6];

  saradc_11b_dig_loopback_chk dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .seed_i         (seed_i),
    .scan_mode_o    (scan_mode_o),
    .lb_vec_o       (lb_vec_o),
    .fold_i         (fold_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .pass_o         (pass_o),
    .err_cnt_o      (err_cnt_o),
    .first_err_idx_o(first_err_idx_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] m_step(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h8020_0003;
    else      return s >> 1;
  endfunction

  function automatic logic [VEC_W-1:0] m_vec(input logic [31:0] l);
    logic [63:0] w;
    w[31:0]  = l;
    w[63:32] = l ^ {l[15:0], l[31:16]};
    return w[VEC_W-1:0];
  endfunction

  function automatic logic [FOLD_W-1:0] m_fold(input logic [VEC_W-1:0] v);
    return v[18:0] ^ v[37:19] ^ v[56:38];
  endfunction

  // Response model: fold of lb_vec_o delayed, tagged with the vector index it belongs to.
  always @(posedge clk_i) begin
    cyc <= start_i ? 0 : cyc + 1;
    hf0 <= m_fold(lb_vec_o);
    ht0 <= cyc - 1;
    hf1 <= hf0;
    ht1 <= ht0;
  end

  assign sel_f  = (mdl_delay == 3) ? hf1 : hf0;
  assign sel_t  = (mdl_delay == 3) ? ht1 : ht0;
  assign fold_i = (mdl_mode == 2) ? '0 :
                  ((mdl_mode == 1) && (sel_t == 17)) ? (sel_f ^ 19'h0_0008) : sel_f;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept_start(input logic [31:0] seed);
    @(negedge clk_i);
    seed_i  = seed;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic adv(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  task automatic do_run(input int id, input logic [31:0] seed, input int exp_err,
                        input int exp_first, input logic exp_pass);
    logic [31:0] l;
    int mism;
    int n;
    bit got;
    l = (seed == 32'h0) ? 32'h1 : seed;
    mism = 0;
    n = 0;
    got = 1'b0;
    accept_start(seed);
    check($sformatf("run%0d_busy_start", id), busy_o, 1);
    check($sformatf("run%0d_scan_start", id), scan_mode_o, 1);
    check($sformatf("run%0d_err_cleared", id), err_cnt_o, 0);
    while (!got && n < 400) begin
      adv(1);
      n++;
      if (n <= NV) begin
        if (lb_vec_o !== m_vec(l)) mism++;
        l = m_step(l);
      end
      if (done_o) got = 1'b1;
    end
    check($sformatf("run%0d_done_edges", id), n + 1, NV + 2 + 1);
    check($sformatf("run%0d_vec_seq", id), mism, 0);
    check($sformatf("run%0d_err_cnt", id), err_cnt_o, exp_err);
    check($sformatf("run%0d_first_idx", id), first_err_idx_o, exp_first);
    check($sformatf("run%0d_pass", id), pass_o, exp_pass);
    check($sformatf("run%0d_vec_zero", id), lb_vec_o, 0);
    check($sformatf("run%0d_busy_end", id), {busy_o, scan_mode_o}, 0);
  endtask

  initial begin
    logic [31:0] l;
    logic [FOLD_W-1:0] f;
    logic [FOLD_W-1:0] prev;
    int nz, nz_first, d3, d3_first;

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; seed_i = 32'h0;

    l = 32'h0000_ACE1; prev = '0;
    nz = 0; nz_first = -1; d3 = 0; d3_first = -1;
    for (int k = 0; k < NV; k++) begin
      f = m_fold(m_vec(l));
      if (f != '0) begin
        nz++;
        if (nz_first < 0) nz_first = k;
      end
      if (f != prev) begin
        d3++;
        if (d3_first < 0) d3_first = k;
      end
      prev = f;
      l = m_step(l);
    end
    if (nz_first < 0) nz_first = 0;
    if (d3_first < 0) d3_first = 0;
    if (nz > 255) nz = 255;
    if (d3 > 255) d3 = 255;

    tbl[0] = '{32'h0000_ACE1, 2, 0, 0,  0,        1'b1};
    tbl[1] = '{32'h0000_ACE1, 2, 1, 1,  17,       1'b0};
    tbl[2] = '{32'h0000_ACE1, 2, 2, nz, nz_first, 1'b0};
    tbl[3] = '{32'h0000_0000, 2, 0, 0,  0,        1'b1};
    tbl[4] = '{32'h0000_0001, 2, 0, 0,  0,        1'b1};
    tbl[5] = '{32'h0000_ACE1, 3, 0, d3, d3_first, (d3 == 0)};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_scan", scan_mode_o, 0);
    check("rst_done", done_o, 0);
    check("rst_pass", pass_o, 0);
    check("rst_vec", lb_vec_o, 0);
    check("rst_err", err_cnt_o, 0);
    check("rst_first", first_err_idx_o, 0);
    rst_i = 1'b0;
    adv(2);
    check("idle_busy", busy_o, 0);

    for (int i = 0; i < 6; i++) begin
      mdl_delay = tbl[i].delay;
      mdl_mode  = tbl[i].mode;
      do_run(i, tbl[i].seed, tbl[i].exp_err, tbl[i].exp_first, tbl[i].exp_pass);
      adv(2);
      check($sformatf("run%0d_hold_done", i), done_o, 1);
    end
    mdl_delay = 2;
    mdl_mode  = 0;

    // abort at RUN cycle 40, start_i ignored alongside it
    accept_start(32'h0000_ACE1);
    adv(39);
    check("abort_pre_busy", busy_o, 1);
    abort_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    check("abort_busy", busy_o, 0);
    check("abort_scan", scan_mode_o, 0);
    check("abort_vec", lb_vec_o, 0);
    check("abort_done", done_o, 0);
    check("abort_err", err_cnt_o, 0);

    // start_i during DRAIN is ignored
    accept_start(32'h1234_5678);
    adv(257);
    check("drain_busy", busy_o, 1);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
    check("drain_start_done", done_o, 1);
    check("drain_start_pass", pass_o, 1);
    adv(3);
    check("drain_start_busy", busy_o, 0);

    // asynchronous reset mid-DRAIN, then a clean run
    accept_start(32'h0000_ACE1);
    adv(257);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_outputs",
          {busy_o, scan_mode_o, done_o, pass_o, err_cnt_o, first_err_idx_o}, 0);
    check("midrst_vec", lb_vec_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    do_run(9, 32'h0000_ACE1, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
